puf_auth_verifier: RTL
======================

# puf_auth_verifier

Verifier side of the ring-oscillator PUF: drives a sequence of challenges into the PUF array, times each measurement window, and captures the synchronized response. It compares each response against an enrolled reference set, accumulates the total Hamming distance, and reports pass/fail against a threshold. It sits between the system controller (enrollment, start, result) and the PUF array (challenge, enable, counter clear, response).

## Interface
- N_CHAL, 8: challenges per authentication; power of two, ≥2
- CHAL_W, 5: challenge width
- RESP_W, 8: PUF response width
- WINDOW, 16: measurement cycles per challenge with puf_en high; ≥1
- HD_THRESH, 6: maximum total Hamming distance for a pass
- HD_W, derived: $clog2(N_CHAL*RESP_W+1)
- IDX_W, derived: $clog2(N_CHAL)

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- enroll_we  in  1  write the reference response for enroll_idx
- enroll_idx  in  IDX_W  reference slot
- enroll_data  in  RESP_W  expected response
- start  in  1  begin authentication; sampled only in IDLE
- chal_seed  in  CHAL_W  base challenge; sampled with start
- puf_challenge  out  CHAL_W  challenge to the PUF mux
- puf_en  out  1  oscillator enable
- puf_clr  out  1  PUF counter clear
- puf_response  in  RESP_W  PUF response; asynchronous to clk
- busy  out  1  high from the cycle after start is accepted through FINISH
- done  out  1  one-cycle pulse in FINISH
- pass  out  1  result; held until the next accepted start
- hd_total  out  HD_W  final accumulated distance; held until the next accepted start

## Operation
- Reference store: N_CHAL × RESP_W registers, cleared to 0 by reset. A write is accepted only in IDLE and is dropped while busy. If enroll_we and start occur in the same IDLE cycle, the write lands first, so the authentication uses the new value.
- Challenge i = chal_seed + i mod 2^CHAL_W. Seed 30 wraps to 31, 0, 1, …
- FSM states:
  - IDLE: outputs quiet. On start, latch the seed, set i=0, clear hd_acc, clear pass and hd_total, go to CLEAR.
  - CLEAR (1 cycle): puf_clr=1, puf_en=0. Go to MEASURE.
  - MEASURE (WINDOW cycles): puf_en=1. Go to SETTLE.
  - SETTLE (3 cycles): puf_en=0. A 2-flop synchronizer on puf_response lets the counter value settle. The synchronized value is captured into resp_q on the last SETTLE cycle. Go to COMPARE.
  - COMPARE (1 cycle): hd_acc += popcount(resp_q ^ ref[i]). If i==N_CHAL-1 go to FINISH; else i++ and go to CLEAR.
  - FINISH (1 cycle): done=1. pass = (final hd_acc ≤ HD_THRESH). hd_total = final hd_acc. Go to IDLE.
- puf_challenge holds the current challenge from CLEAR through COMPARE, and 0 in IDLE.
- Accumulator width is HD_W, so it cannot overflow.
- start while busy: ignored.

## Timing
- Reset values: puf_challenge=0, puf_en=0, puf_clr=0, busy=0, done=0, pass=0, hd_total=0, state=IDLE, all reference registers 0.
- Per challenge: WINDOW+5 cycles (1 CLEAR + WINDOW MEASURE + 3 SETTLE + 1 COMPARE).
- If start is sampled at edge k, done is high in the cycle beginning at edge k+1+N_CHAL*(WINDOW+5).
- pass and hd_total become valid in the same cycle as done.
- All outputs are registered.
- Reset asserted at any point, including mid-MEASURE: all state returns to reset values immediately. No done pulse is produced, and enrolled data is lost.

## Structure
- Package puf_pkg:
  - state enum: IDLE, CLEAR, MEASURE, SETTLE, COMPARE, FINISH
  - default CHAL_W/RESP_W constants, shared with the PUF top
- Sub-module puf_hd_popcount: combinational popcount of RESP_W-bit XOR, output width $clog2(RESP_W+1).
- Window and settle counting use one shared down-counter.

## Test plan
All scenarios use the default parameters.
- Enroll slots 0–7 with 0xA5; the PUF model returns 0xA5; start with seed 0 → done 169 cycles later, pass=1, hd_total=0.
- The model returns 0xA4 for every challenge → hd_total=8, pass=0.
- Threshold boundary: mismatches summing to 6 bits → pass=1; summing to 7 → pass=0.
- Seed 30 → puf_challenge sequence is 30,31,0,1,2,3,4,5. Each challenge gets exactly one puf_clr pulse and exactly 16 consecutive puf_en cycles.
- Assert reset during MEASURE of index 3 → all outputs return to reset values in the same cycle, and no done pulse is produced. Re-enroll and start again → normal completion.
- start and enroll_we asserted while busy → no restart, references unchanged, and the original run finishes with the expected hd_total.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and default widths for the ring-oscillator PUF verifier.
package puf_pkg;

  localparam int CHAL_W_DEF = 5;
  localparam int RESP_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MEASURE,
    SETTLE,
    COMPARE,
    FINISH
  } state_e;

endpackage

// File: rtl/puf_hd_popcount.sv
// Combinational Hamming distance between a captured PUF response and its reference.
module puf_hd_popcount #(
  parameter int RESP_W = 8,
  parameter int POP_W  = $clog2(RESP_W + 1)
) (
  input  logic [RESP_W-1:0] resp,
  input  logic [RESP_W-1:0] expected,
  output logic [POP_W-1:0]  distance
);

  logic [RESP_W-1:0] diff;

  assign diff = resp ^ expected;

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    distance = '0;
    for (int i = 0; i < RESP_W; i++) begin
      distance = distance + POP_W'(diff[i]);
    end
  end

endmodule

// File: rtl/puf_auth_verifier.sv
// PUF verifier: sequences challenges, times measurement windows, and scores responses
// against the enrolled references by total Hamming distance.
module puf_auth_verifier
  import puf_pkg::*;
#(
  parameter int N_CHAL    = 8,
  parameter int CHAL_W    = CHAL_W_DEF,
  parameter int RESP_W    = RESP_W_DEF,
  parameter int WINDOW    = 16,
  parameter int HD_THRESH = 6,
  parameter int HD_W      = $clog2(N_CHAL * RESP_W + 1),
  parameter int IDX_W     = $clog2(N_CHAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enroll_we,
  input  logic [IDX_W-1:0]  enroll_idx,
  input  logic [RESP_W-1:0] enroll_data,
  input  logic              start,
  input  logic [CHAL_W-1:0] chal_seed,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_en,
  output logic              puf_clr,
  input  logic [RESP_W-1:0] puf_response,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [HD_W-1:0]   hd_total
);

  localparam int POP_W      = $clog2(RESP_W + 1);
  localparam int SETTLE_CYC = 3;
  localparam int CNT_MAX    = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX);

  state_e            state;
  logic [CHAL_W-1:0] seed;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [HD_W-1:0]   hd_acc;
  logic [RESP_W-1:0] resp_sync1;
  logic [RESP_W-1:0] resp_sync2;
  logic [RESP_W-1:0] resp_q;
  logic [RESP_W-1:0] ref_mem [N_CHAL];
  logic [POP_W-1:0]  hd_step;
  logic              accept_ok;

  // Outputs trail the state by one register stage, so busy also covers the cycle after FINISH.
  assign accept_ok = (state == IDLE) && !busy;

  // NOTE: the reference store is reset explicitly because a reset must discard enrolled data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CHAL; i++) begin
        ref_mem[i] <= '0;
      end
    end else if (accept_ok && enroll_we) begin
      ref_mem[enroll_idx] <= enroll_data;
    end
  end

  // puf_response comes from free-running oscillator counters, hence the two-flop synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_sync1 <= '0;
      resp_sync2 <= '0;
    end else begin
      resp_sync1 <= puf_response;
      resp_sync2 <= resp_sync1;
    end
  end

  puf_hd_popcount #(
    .RESP_W(RESP_W),
    .POP_W (POP_W)
  ) u_popcount (
    .resp    (resp_q),
    .expected(ref_mem[idx]),
    .distance(hd_step)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      seed          <= '0;
      idx           <= '0;
      cnt           <= '0;
      hd_acc        <= '0;
      resp_q        <= '0;
      puf_challenge <= '0;
      puf_en        <= 1'b0;
      puf_clr       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      hd_total      <= '0;
    end else begin
      puf_clr       <= (state == CLEAR);
      puf_en        <= (state == MEASURE);
      busy          <= (state != IDLE);
      done          <= (state == FINISH);
      puf_challenge <= (state == IDLE || state == FINISH) ? '0 : seed + CHAL_W'(idx);

      case (state)
        IDLE: begin
          if (start && accept_ok) begin
            seed     <= chal_seed;
            idx      <= '0;
            hd_acc   <= '0;
            pass     <= 1'b0;
            hd_total <= '0;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= CNT_W'(WINDOW - 1);
          state <= MEASURE;
        end
        MEASURE: begin
          // One down-counter times both the measurement window and the settle interval.
          if (cnt == '0) begin
            cnt   <= CNT_W'(SETTLE_CYC - 1);
            state <= SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            resp_q <= resp_sync2;
            state  <= COMPARE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        COMPARE: begin
          hd_acc <= hd_acc + HD_W'(hd_step);
          if (idx == IDX_W'(N_CHAL - 1)) begin
            state <= FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= CLEAR;
          end
        end
        FINISH: begin
          pass     <= (hd_acc <= HD_W'(HD_THRESH));
          hd_total <= hd_acc;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
